// File: rtl/seg7_scan.sv
// Time-multiplexed 3-digit BCD display scanner with per-frame input snapshot,
// leading-zero blanking, decimal point and per-slot anode dead time.
module seg7_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] y2,
    input  logic [3:0] y1,
    input  logic [3:0] y0,
    input  logic       blank_lz,
    input  logic       dp_en,
    input  logic [1:0] dp_sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp_n,
    output logic       frame_start
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       slot_reg;
    logic             tick;
    logic             snap;
    logic             dead;

    logic [2:0][3:0]  digit_sh_reg;
    logic             blank_lz_sh_reg;
    logic             dp_en_sh_reg;
    logic [1:0]       dp_sel_sh_reg;

    // Index 3 is the permanently dark slot so slot_reg can index directly.
    logic [3:0][6:0]  digit_seg;
    logic [3:0]       digit_dp;
    logic [3:0]       digit_blank;

    logic [3:0]       an_reg;
    logic [3:0]       an_next;
    logic [6:0]       seg_reg;
    logic [6:0]       seg_next;
    logic             dp_n_reg;
    logic             dp_n_next;
    logic             frame_start_reg;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick = (cnt_reg == CNT_LAST);
    assign snap = tick && (slot_reg == 2'd3);

    generate
        if (BLANK_CYC == 0) begin : g_no_dead
            assign dead = 1'b0;
        end else begin : g_dead
            localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
            assign dead = (cnt_reg < BLANK_LIM);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            slot_reg <= 2'd0;
        end else begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
            if (tick) begin
                slot_reg <= slot_reg + 2'd1;
            end
        end
    end

    // Inputs are only sampled once per frame so a counter rolling over
    // mid-scan cannot tear the displayed value.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_sh_reg    <= '0;
            blank_lz_sh_reg <= 1'b0;
            dp_en_sh_reg    <= 1'b0;
            dp_sel_sh_reg   <= 2'd0;
            frame_start_reg <= 1'b0;
        end else begin
            frame_start_reg <= snap;
            if (snap) begin
                digit_sh_reg    <= {y2, y1, y0};
                blank_lz_sh_reg <= blank_lz;
                dp_en_sh_reg    <= dp_en;
                dp_sel_sh_reg   <= dp_sel;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            assign digit_seg[gi] = bcd_to_seg(digit_sh_reg[gi]);
            assign digit_dp[gi]  = dp_en_sh_reg && (dp_sel_sh_reg == 2'(gi));
        end
    endgenerate

    assign digit_seg[3] = 7'b1111111;
    assign digit_dp[3]  = 1'b0;

    // A lit decimal point keeps its digit visible and stops the zero chain.
    assign digit_blank[3] = 1'b1;
    assign digit_blank[2] = blank_lz_sh_reg && (digit_sh_reg[2] == 4'd0) && !digit_dp[2];
    assign digit_blank[1] = digit_blank[2] && (digit_sh_reg[1] == 4'd0) && !digit_dp[1];
    assign digit_blank[0] = 1'b0;

    always_comb begin
        an_next   = 4'b1111;
        seg_next  = 7'b1111111;
        dp_n_next = 1'b1;
        if (!dead && !digit_blank[slot_reg]) begin
            an_next[slot_reg] = 1'b0;
            seg_next          = digit_seg[slot_reg];
            dp_n_next         = !digit_dp[slot_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_reg   <= 4'b1111;
            seg_reg  <= 7'b1111111;
            dp_n_reg <= 1'b1;
        end else begin
            an_reg   <= an_next;
            seg_reg  <= seg_next;
            dp_n_reg <= dp_n_next;
        end
    end

    assign an          = an_reg;
    assign seg         = seg_reg;
    assign dp_n        = dp_n_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with REFRESH_DIV = 8, BLANK_CYC = 2:
// table of digit patterns checked cycle by cycle through a scoreboard queue.
module tb_seg7_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] y2, y1, y0;
    logic       blank_lz, dp_en;
    logic [1:0] dp_sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n, frame_start;

    int checks = 0;
    int errors = 0;

    seg7_scan #(.REFRESH_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .y2(y2), .y1(y1), .y0(y0),
        .blank_lz(blank_lz), .dp_en(dp_en), .dp_sel(dp_sel),
        .an(an), .seg(seg), .dp_n(dp_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      y2, y1, y0;
        logic            blz, dpen;
        logic [1:0]      dpsel;
        logic [2:0][3:0] an_e;   // {slot2, slot1, slot0}
        logic [2:0][6:0] seg_e;
        logic [2:0]      dpn_e;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpn;
        logic       fs;
        bit         chk_seg;
        int         tag;
        int         n;
    } exp_t;

    vec_t vecs[8];
    vec_t vzero, v456;
    exp_t sbq[$];

    task automatic drive(input vec_t v);
        y2 = v.y2; y1 = v.y1; y0 = v.y0;
        blank_lz = v.blz; dp_en = v.dpen; dp_sel = v.dpsel;
    endtask

    // Output seen after the n-th edge of a frame reflects frame position n-1.
    function automatic exp_t expect_at(input vec_t v, input int n, input int tag);
        exp_t e;
        int p, sl, c;
        p = n - 1; sl = p / 8; c = p % 8;
        e.an = 4'b1111; e.seg = 7'b1111111; e.dpn = 1'b1;
        e.fs = (n == 32); e.chk_seg = 1'b1; e.tag = tag; e.n = n;
        if (c >= 2) begin
            if (sl == 3) begin
                e.chk_seg = 1'b0;
            end else begin
                e.an  = v.an_e[sl];
                e.seg = v.seg_e[sl];
                e.dpn = v.dpn_e[sl];
            end
        end
        return e;
    endfunction

    task automatic compare_head();
        exp_t e;
        e = sbq.pop_front();
        checks++;
        if (an !== e.an) begin
            errors++;
            $display("FAIL an tag%0d n%0d got %b want %b", e.tag, e.n, an, e.an);
        end
        if (e.chk_seg) begin
            checks++;
            if (seg !== e.seg) begin
                errors++;
                $display("FAIL seg tag%0d n%0d got %b want %b", e.tag, e.n, seg, e.seg);
            end
        end
        checks++;
        if (dp_n !== e.dpn) begin
            errors++;
            $display("FAIL dp_n tag%0d n%0d got %b want %b", e.tag, e.n, dp_n, e.dpn);
        end
        checks++;
        if (frame_start !== e.fs) begin
            errors++;
            $display("FAIL frame_start tag%0d n%0d got %b want %b", e.tag, e.n, frame_start, e.fs);
        end
    endtask

    // Called at a negedge just after a snapshot edge (or reset release).
    task automatic run_frame(input vec_t v, input int tag, input int n_last,
                             input int mid_n, input vec_t mid_v);
        for (int n = 1; n <= n_last; n++) begin
            sbq.push_back(expect_at(v, n, tag));
            @(posedge clk);
            @(negedge clk);
            compare_head();
            if (n == mid_n) drive(mid_v);
        end
        $display("frame tag%0d cycles %0d checked", tag, n_last);
    endtask

    task automatic wait_frame(input int tag);
        bit found = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_timeout tag%0d got no pulse want pulse within 80 cycles", tag);
        end
    endtask

    task automatic check_dark(input string name);
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp_n !== 1'b1 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL %s got an=%b seg=%b dp_n=%b fs=%b want 1111 1111111 1 0",
                     name, an, seg, dp_n, frame_start);
        end
        $display("%s an=%b seg=%b dp_n=%b fs=%b", name, an, seg, dp_n, frame_start);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vzero   = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0,
                    {4'b1011, 4'b1101, 4'b1110},
                    {7'b1000000, 7'b1000000, 7'b1000000}, 3'b111};
        v456    = '{4'd4, 4'd5, 4'd6, 1'b0, 1'b0, 2'd3,
                    {4'b1011, 4'b1101, 4'b1110},
                    {7'b0011001, 7'b0010010, 7'b0000010}, 3'b111};
        vecs[0] = '{4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 2'd3,
                    {4'b1011, 4'b1101, 4'b1110},
                    {7'b1111001, 7'b0100100, 7'b0110000}, 3'b111};
        vecs[1] = '{4'd0, 4'd0, 4'd5, 1'b1, 1'b0, 2'd3,
                    {4'b1111, 4'b1111, 4'b1110},
                    {7'b1111111, 7'b1111111, 7'b0010010}, 3'b111};
        vecs[2] = '{4'd0, 4'd0, 4'd5, 1'b1, 1'b1, 2'd1,
                    {4'b1111, 4'b1101, 4'b1110},
                    {7'b1111111, 7'b1000000, 7'b0010010}, 3'b101};
        vecs[3] = '{4'd0, 4'd12, 4'd7, 1'b1, 1'b0, 2'd0,
                    {4'b1111, 4'b1101, 4'b1110},
                    {7'b1111111, 7'b0111111, 7'b1111000}, 3'b111};
        vecs[4] = '{4'd9, 4'd8, 4'd6, 1'b1, 1'b1, 2'd0,
                    {4'b1011, 4'b1101, 4'b1110},
                    {7'b0010000, 7'b0000000, 7'b0000010}, 3'b110};
        vecs[5] = '{4'd0, 4'd4, 4'd0, 1'b1, 1'b1, 2'd2,
                    {4'b1011, 4'b1101, 4'b1110},
                    {7'b1000000, 7'b0011001, 7'b1000000}, 3'b011};
        vecs[6] = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 2'd3,
                    {4'b1011, 4'b1101, 4'b1110},
                    {7'b1000000, 7'b1000000, 7'b1000000}, 3'b111};
        vecs[7] = '{4'd15, 4'd10, 4'd11, 1'b1, 1'b0, 2'd3,
                    {4'b1011, 4'b1101, 4'b1110},
                    {7'b0111111, 7'b0111111, 7'b0111111}, 3'b111};

        // Reset held three cycles, then the first frame from zeroed shadows.
        rst = 1'b1;
        drive(vecs[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_dark("reset_hold");
        end
        rst = 1'b0;
        run_frame(vzero, 100, 32, 0, vzero);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i]);
            wait_frame(i);
            run_frame(vecs[i], i, 32, 0, vzero);
        end

        // Inputs change during slot 1; the running frame keeps the old snapshot.
        drive(vecs[0]);
        wait_frame(200);
        run_frame(vecs[0], 200, 32, 10, v456);
        run_frame(v456, 201, 32, 0, vzero);

        // Reset pulse during slot 2 restarts the scan from zeroed shadows.
        drive(vecs[0]);
        wait_frame(300);
        run_frame(vecs[0], 300, 20, 0, vzero);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_dark("midscan_reset");
        rst = 1'b0;
        run_frame(vzero, 301, 32, 0, vzero);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
